fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 Parameter DEPTH, 2, instruction buffer entries; also the maximum outstanding-plus-buffered count.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 imem_req  out  1  fetch request valid.
REQ-006 imem_addr  out  32  word-aligned fetch address; bits [1:0] always 0.
REQ-007 imem_gnt  in  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  in  1  read data valid; responses return in request order, latency >= 1 cycle.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 redirect_e  in  1  taken branch or jump from execute; flush and refetch.
REQ-011 redirect_pc_e  in  32  redirect target; bits [1:0] ignored.
REQ-012 valid_d  out  1  instr_d, pc_d and pcplus4_d are valid for decode.
REQ-013 ready_d  in  1  decode consumes the head entry; low means stall.
REQ-014 instr_d  out  32  instruction to decode.
REQ-015 pc_d  out  32  address of instr_d.
REQ-016 pcplus4_d  out  32  pc_d + 4, modulo 2^32.

Function
REQ-017 Fetch PC register (fpc) shall hold the next address to request; imem_addr = fpc except in a redirect cycle, where imem_addr = {redirect_pc_e[31:2],2'b00}.
REQ-018 Credit: imem_req shall be 1 only when outstanding + occupancy < DEPTH, counting outstanding stale requests.
REQ-019 Handshake: a request completes when imem_req & imem_gnt; fpc then advances to the issued address + 4, wrapping modulo 2^32.
REQ-020 imem_req and imem_addr shall stay stable while imem_req=1 and imem_gnt=0, unless redirect_e=1.
REQ-021 Each accepted request shall push {addr, addr+4} into an in-order tag queue; its rdata push into the buffer with that tag on imem_rvalid.
REQ-022 valid_d = (occupancy != 0) & ~redirect_e; the head entry pops when valid_d & ready_d.
REQ-023 When valid_d=0, instr_d shall be 32'h0000_0013 (NOP), pc_d = 0, and pcplus4_d = 0.
REQ-024 Push and pop in the same cycle shall leave occupancy unchanged; a response arriving into an empty buffer is visible on valid_d the next cycle; there is no bypass.
REQ-025 Redirect cycle: empty the buffer; mark all currently outstanding requests stale via a discard counter; a request to the target may issue in that same cycle if credit allows.
REQ-026 A stale response shall decrement the discard counter and be dropped; the tag queue pops without pushing to the buffer; this includes an rvalid in the redirect cycle itself.
REQ-027 A redirect during a stale drain shall add the new outstanding requests to the discard counter and retarget fpc.
REQ-028 A second redirect before a previous target is fetched shall make the latest target win.
REQ-029 FSM: BOOT for one cycle after reset release with imem_req=0, then RUN; there are no other states.
REQ-030 imem_rvalid with zero outstanding requests is a protocol error; ignore it and trigger an assertion.

Reset
REQ-031 Asynchronous reset shall set fpc=RESET_PC, state=BOOT, buffer/tag queue/outstanding/discard counters to 0, imem_req=0, imem_addr=RESET_PC, and valid_d=0.
REQ-032 Reset mid-transfer: in-flight responses after reset release are the memory's responsibility to suppress; the block holds no stale state.

Structure
REQ-033 Shared package: NOP_INSTR, XLEN=32, and the fetch FSM state enum.
REQ-034 One sub-module, fetch_fifo: a DEPTH-entry synchronous FIFO with push, pop, flush, full, empty, and occupancy ports; used for both the tag queue and the instruction buffer.

Verification
REQ-035 Reset, gnt=1, 1-cycle latency, ready_d=1: addresses 0,4,8... issue, and first valid_d shows pc_d=0, pcplus4_d=4.
REQ-036 ready_d=0 for 10 cycles: at most 2 requests issue, then imem_req=0; on release, entries drain in order with no loss or duplication.
REQ-037 Redirect to 32'h0000_0103 with 2 requests outstanding: those responses are dropped, imem_addr=32'h0000_0100 the same cycle, and next valid pc_d=32'h100.
REQ-038 gnt held 0 for 5 cycles: imem_addr stays stable; a redirect during the hold changes imem_addr to the target.
REQ-039 fpc=32'hFFFF_FFFC: next request address 32'h0000_0000, and pcplus4_d=0.
REQ-040 rvalid coincident with redirect, and back-to-back redirects: no stale instruction is ever presented with valid_d=1.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: word size, the NOP
// presented to decode when idle, and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int              XLEN      = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        BOOT,
        RUN
    } fetchState_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with flush; serves as both the in-order tag
// queue and the instruction buffer of the fetch unit.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             pushData,
    output logic [WIDTH-1:0]             headData,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             doPush;
    logic             doPop;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (occupancy == CNT_W'(DEPTH));
    assign empty    = (occupancy == '0);
    assign doPop    = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign doPush   = push & (~full | doPop);
    assign headData = mem[rdPtr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            occupancy <= '0;
        end else if (flush) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            occupancy <= '0;
        end else begin
            if (doPush) wrPtr <= nextPtr(wrPtr);
            if (doPop)  rdPtr <= nextPtr(rdPtr);
            occupancy <= occupancy + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    always_ff @(posedge clk) begin
        if (doPush && !flush) mem[wrPtr] <= pushData;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order tag
// tracking, stale-response discard after redirects, and a decode-side buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_e,
    input  logic [31:0] redirect_pc_e,
    output logic        valid_d,
    input  logic        ready_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pcplus4_d
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    fetchState_t       state;
    fetchState_t       stateNext;
    logic [XLEN-1:0]   fpc;
    logic [XLEN-1:0]   fpcNext;
    logic [XLEN-1:0]   targetPc;
    logic [CNT_W-1:0]  tagCount;
    logic [CNT_W-1:0]  bufCount;
    logic [CNT_W-1:0]  discardCnt;
    logic [CNT_W-1:0]  discardNext;
    logic [CNT_W:0]    creditUsed;
    logic              tagFull;
    logic              tagEmpty;
    logic              bufFull;
    logic              bufEmpty;
    logic              fire;
    logic              tagPop;
    logic              stale;
    logic              bufPush;
    logic              bufPop;
    logic [2*XLEN-1:0] tagHead;
    logic [3*XLEN-1:0] bufHead;
    logic              unusedBits;

    assign unusedBits = ^{redirect_pc_e[1:0], tagFull, bufFull};

    assign fire    = imem_req & imem_gnt;
    assign tagPop  = imem_rvalid & ~tagEmpty;
    // Everything outstanding at a redirect is stale, including a response landing that cycle.
    assign stale   = redirect_e | (discardCnt != '0);
    assign bufPush = tagPop & ~stale;
    assign valid_d = ~bufEmpty & ~redirect_e;
    assign bufPop  = valid_d & ready_d;
    // The buffer is emptied by a redirect, so its entries no longer hold credit that cycle.
    assign creditUsed = {1'b0, tagCount} + (redirect_e ? '0 : {1'b0, bufCount});

    fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) tagQueue (
        .clk       (clk),
        .reset     (reset),
        .push      (fire),
        .pop       (tagPop),
        .flush     (1'b0),
        .pushData  ({imem_addr, imem_addr + 32'd4}),
        .headData  (tagHead),
        .full      (tagFull),
        .empty     (tagEmpty),
        .occupancy (tagCount)
    );

    fetch_fifo #(.WIDTH(3*XLEN), .DEPTH(DEPTH)) instrBuf (
        .clk       (clk),
        .reset     (reset),
        .push      (bufPush),
        .pop       (bufPop),
        .flush     (redirect_e),
        .pushData  ({imem_rdata, tagHead}),
        .headData  (bufHead),
        .full      (bufFull),
        .empty     (bufEmpty),
        .occupancy (bufCount)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= BOOT;
            fpc        <= RESET_PC;
            discardCnt <= '0;
        end else begin
            state      <= stateNext;
            fpc        <= fpcNext;
            discardCnt <= discardNext;
        end
    end

    always_comb begin
        stateNext   = RUN;
        targetPc    = {redirect_pc_e[XLEN-1:2], 2'b00};
        imem_addr   = redirect_e ? targetPc : fpc;
        imem_req    = (state == RUN) && (creditUsed < (CNT_W+1)'(DEPTH));
        fpcNext     = fpc;
        discardNext = discardCnt;
        if (imem_req && imem_gnt) begin
            fpcNext = imem_addr + 32'd4;
        end else if (redirect_e) begin
            fpcNext = targetPc;
        end
        if (redirect_e) begin
            discardNext = tagCount - CNT_W'(tagPop);
        end else if (tagPop && discardCnt != '0) begin
            discardNext = discardCnt - CNT_W'(1);
        end
    end

    always_comb begin
        instr_d   = NOP_INSTR;
        pc_d      = '0;
        pcplus4_d = '0;
        if (valid_d) {instr_d, pc_d, pcplus4_d} = bufHead;
    end

    rvalidNeedsRequest: assert property (@(posedge clk) disable iff (reset) imem_rvalid |-> !tagEmpty);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cycle table, hand-written
// stall/hold/redirect sequences, and randomized traffic against a transaction model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int   DEPTH = 2;
    localparam bit   H = 1'b1;
    localparam bit   L = 1'b0;
    localparam int   NVEC = 17;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_e;
    logic [31:0] redirect_pc_e;
    logic        valid_d;
    logic        ready_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_e    (redirect_e),
        .redirect_pc_e (redirect_pc_e),
        .valid_d       (valid_d),
        .ready_d       (ready_d),
        .instr_d       (instr_d),
        .pc_d          (pc_d),
        .pcplus4_d     (pcplus4_d)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        gnt;
        logic        rv;
        logic [31:0] rvAddr;
        logic        rd;
        logic [31:0] tgt;
        logic        rdy;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] ePc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          issued;
        bit          stale;
    } memReq_t;

    vec_t        vecs [NVEC];
    memReq_t     memQ [$];
    int          total = 0;
    int          bad = 0;
    int          occ;
    int          cyc = 0;
    int          hsCount;
    int          consumeCount;
    bit          bootCyc;
    logic [31:0] expFetch;
    logic [31:0] expPc;
    logic [31:0] firstPc;
    logic [31:0] holdAddr;

    function automatic logic [31:0] instrOf(input logic [31:0] a);
        return a ^ 32'h8BAD_F00D;
    endfunction

    function automatic vec_t mk(input bit g, input bit rv, input logic [31:0] rva, input bit rd,
                                input logic [31:0] tgt, input bit rdy, input bit eReq,
                                input logic [31:0] eAddr, input bit eV, input logic [31:0] ePc);
        vec_t v;
        v.gnt = g; v.rv = rv; v.rvAddr = rva; v.rd = rd; v.tgt = tgt; v.rdy = rdy;
        v.eReq = eReq; v.eAddr = eAddr; v.eValid = eV; v.ePc = ePc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic setIdle();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect_e = 1'b0; redirect_pc_e = '0; ready_d = 1'b0;
    endtask

    // Asynchronous assertion checked between clock edges, released just after a rising edge.
    task automatic doReset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        setIdle();
        #1;
        check("rst_req",   32'(imem_req), 32'd0);
        check("rst_addr",  imem_addr, 32'h0000_0000);
        check("rst_valid", 32'(valid_d), 32'd0);
        check("rst_instr", instr_d, NOP_INSTR);
        check("rst_pc",    pc_d, 32'd0);
        check("rst_pc4",   pcplus4_d, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        memQ.delete();
        occ = 0;
        expFetch = 32'h0000_0000;
        expPc = 32'h0000_0000;
        bootCyc = 1'b1;
    endtask

    // One clock of traffic: memory model responds in order, then every output is checked.
    task automatic runCycle(input bit g, input bit rd, input logic [31:0] tgt, input bit rdy, input bit respOk);
        logic [31:0] tgtA;
        bit          rv;
        bit          hs;
        bit          headStale;
        bit          expReq;
        bit          expValid;
        int          used;
        @(negedge clk);
        tgtA = {tgt[31:2], 2'b00};
        rv = respOk && (memQ.size() != 0) && (memQ[0].issued < cyc);
        imem_gnt = g; redirect_e = rd; redirect_pc_e = tgt; ready_d = rdy;
        imem_rvalid = rv;
        imem_rdata = rv ? instrOf(memQ[0].addr) : 32'hDEAD_BEEF;
        #1;
        used = memQ.size() + (rd ? 0 : occ);
        expReq = !bootCyc && (used < DEPTH);
        expValid = (occ != 0) && !rd;
        check("req",   32'(imem_req), 32'(expReq));
        check("addr",  imem_addr, rd ? tgtA : expFetch);
        check("valid", 32'(valid_d), 32'(expValid));
        if (expValid) begin
            check("pc",    pc_d, expPc);
            check("instr", instr_d, instrOf(expPc));
            check("pc4",   pcplus4_d, expPc + 32'd4);
            if (rdy) begin
                if (consumeCount == 0) firstPc = pc_d;
                consumeCount++;
                expPc = expPc + 32'd4;
            end
        end else begin
            check("nop_instr", instr_d, NOP_INSTR);
            check("nop_pc",    pc_d, 32'd0);
            check("nop_pc4",   pcplus4_d, 32'd0);
        end
        hs = imem_req && g;
        headStale = 1'b0;
        if (rv) begin
            headStale = memQ[0].stale || rd;
            void'(memQ.pop_front());
        end
        if (rd) begin
            foreach (memQ[i]) memQ[i].stale = 1'b1;
            occ = 0;
            expPc = tgtA;
        end else begin
            if (expValid && rdy) occ--;
            if (rv && !headStale) occ++;
        end
        if (hs) begin
            memQ.push_back('{imem_addr, cyc, 1'b0});
            expFetch = imem_addr + 32'd4;
            hsCount++;
        end else if (rd) begin
            expFetch = tgtA;
        end
        bootCyc = 1'b0;
        cyc++;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: time limit reached at t=%0t, want summary before it", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        setIdle();
        vecs[0]  = mk(H, L, 32'h0,        L, 32'h0,        H, L, 32'h0,        L, 32'h0);
        vecs[1]  = mk(H, L, 32'h0,        L, 32'h0,        H, H, 32'h0,        L, 32'h0);
        vecs[2]  = mk(H, H, 32'h0,        L, 32'h0,        H, H, 32'h4,        L, 32'h0);
        vecs[3]  = mk(H, H, 32'h4,        L, 32'h0,        H, L, 32'h8,        H, 32'h0);
        vecs[4]  = mk(H, L, 32'h0,        L, 32'h0,        H, H, 32'h8,        H, 32'h4);
        vecs[5]  = mk(H, H, 32'h8,        L, 32'h0,        H, H, 32'hC,        L, 32'h0);
        vecs[6]  = mk(H, H, 32'hC,        L, 32'h0,        H, L, 32'h10,       H, 32'h8);
        vecs[7]  = mk(H, L, 32'h0,        L, 32'h0,        H, H, 32'h10,       H, 32'hC);
        vecs[8]  = mk(H, L, 32'h0,        L, 32'h0,        H, H, 32'h14,       L, 32'h0);
        vecs[9]  = mk(H, H, 32'h10,       H, 32'h103,      H, L, 32'h100,      L, 32'h0);
        vecs[10] = mk(H, H, 32'h14,       L, 32'h0,        H, H, 32'h100,      L, 32'h0);
        vecs[11] = mk(H, H, 32'h100,      L, 32'h0,        H, H, 32'h104,      L, 32'h0);
        vecs[12] = mk(H, H, 32'h104,      L, 32'h0,        H, L, 32'h108,      H, 32'h100);
        vecs[13] = mk(H, L, 32'h0,        H, 32'hFFFF_FFFE, H, H, 32'hFFFF_FFFC, L, 32'h0);
        vecs[14] = mk(H, H, 32'hFFFF_FFFC, L, 32'h0,       H, H, 32'h0,        L, 32'h0);
        vecs[15] = mk(H, H, 32'h0,        L, 32'h0,        H, L, 32'h4,        H, 32'hFFFF_FFFC);
        vecs[16] = mk(H, L, 32'h0,        L, 32'h0,        H, H, 32'h4,        H, 32'h0);

        doReset();
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            imem_gnt = vecs[i].gnt;
            imem_rvalid = vecs[i].rv;
            imem_rdata = instrOf(vecs[i].rvAddr);
            redirect_e = vecs[i].rd;
            redirect_pc_e = vecs[i].tgt;
            ready_d = vecs[i].rdy;
            #1;
            check($sformatf("v%0d_req", i),   32'(imem_req), 32'(vecs[i].eReq));
            check($sformatf("v%0d_addr", i),  imem_addr, vecs[i].eAddr);
            check($sformatf("v%0d_valid", i), 32'(valid_d), 32'(vecs[i].eValid));
            check($sformatf("v%0d_pc", i),    pc_d, vecs[i].eValid ? vecs[i].ePc : 32'h0);
            check($sformatf("v%0d_instr", i), instr_d, vecs[i].eValid ? instrOf(vecs[i].ePc) : NOP_INSTR);
            check($sformatf("v%0d_pc4", i),   pcplus4_d, vecs[i].eValid ? vecs[i].ePc + 32'd4 : 32'h0);
        end

        // Decode stall: issue stops once credit is exhausted, then drains in order.
        doReset();
        hsCount = 0;
        consumeCount = 0;
        repeat (10) runCycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check("stall_issued", 32'(hsCount), 32'd2);
        check("stall_req_low", 32'(imem_req), 32'd0);
        repeat (10) runCycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        check("stall_drained", 32'(consumeCount >= 2), 32'd1);
        check("stall_first_pc", firstPc, 32'h0);

        // Grant withheld: request stays put, a redirect still retargets it.
        repeat (3) runCycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        holdAddr = imem_addr;
        for (int i = 0; i < 5; i++) begin
            runCycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            check("hold_addr", imem_addr, holdAddr);
            check("hold_req", 32'(imem_req), 32'd1);
        end
        consumeCount = 0;
        runCycle(1'b0, 1'b1, 32'h0000_0201, 1'b1, 1'b1);
        check("hold_redir_addr", imem_addr, 32'h0000_0200);
        repeat (8) runCycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        check("hold_redir_first", firstPc, 32'h0000_0200);

        // Back-to-back redirects with responses in flight: the latest target wins.
        consumeCount = 0;
        runCycle(1'b1, 1'b1, 32'h0000_0300, 1'b1, 1'b1);
        runCycle(1'b1, 1'b1, 32'h0000_0402, 1'b1, 1'b1);
        repeat (8) runCycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        check("b2b_first", firstPc, 32'h0000_0400);

        // Randomized traffic, then a quiet period that must make progress.
        doReset();
        for (int i = 0; i < 2000; i++) begin
            runCycle(($urandom % 4) != 0, ($urandom % 8) == 0, $urandom,
                     ($urandom % 3) != 0, ($urandom % 3) != 0);
        end
        consumeCount = 0;
        repeat (20) runCycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        check("live_progress", 32'(consumeCount > 0), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
